// File: rtl/perf_event_monitor_if.sv
// rtl/perf_event_monitor_if.sv - counter dump stream between the monitor and its consumer
// The monitor is the master and drives one counter word per index.
interface perf_event_monitor_if #(
  parameter int CNT_WIDTH = 32,
  parameter int IW        = 3
);
  logic                 dump_valid;
  logic                 dump_ready;
  logic [CNT_WIDTH-1:0] dump_data;
  logic [IW-1:0]        dump_idx;
  logic                 dump_last;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_idx,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_idx,
    input  dump_last,
    output dump_ready
  );
endinterface

// File: rtl/perf_event_monitor.sv
// rtl/perf_event_monitor.sv - cycle/retire/event counters, frozen and dumped on halt
// Index 0 counts cycles, 1 counts retired instructions, 2+i counts event_in[i].
module perf_event_monitor #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int SATURATE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    retire,
  input  logic [NUM_EVENTS-1:0]   event_in,
  input  logic                    halt,
  perf_event_monitor_if.master    dump,
  output logic [NUM_EVENTS+1:0]   ovf,
  output logic [1:0]              state
);

  localparam int NCNT = NUM_EVENTS + 2;
  localparam int IW   = $clog2(NCNT);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    DUMP = 2'b01,
    DONE = 2'b10
  } stateT;

  stateT                stateQ;
  stateT                stateD;
  logic [IW-1:0]        dumpIdx;
  logic [IW-1:0]        idxD;
  logic                 dumpLast;
  logic [CNT_WIDTH-1:0] dumpData;
  logic [CNT_WIDTH-1:0] cnt [NCNT];
  logic [NCNT-1:0]      ovfQ;
  logic [NCNT-1:0]      incVec;

  // Counters only move while running and enabled; DUMP/DONE keep the snapshot frozen.
  assign incVec = (stateQ == RUN && enable) ? {event_in, retire, 1'b1} : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      ovfQ <= '0;
    end else if (clear) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      ovfQ <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        if (incVec[i]) begin
          if (cnt[i] == '1) begin
            ovfQ[i] <= 1'b1;
            if (SATURATE == 0) cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ  <= RUN;
      dumpIdx <= '0;
    end else begin
      stateQ  <= stateD;
      dumpIdx <= idxD;
    end
  end

  assign dumpLast = (stateQ == DUMP) && (dumpIdx == IW'(NCNT - 1));

  always_comb begin
    stateD = stateQ;
    idxD   = dumpIdx;
    if (clear) begin
      stateD = RUN;
      idxD   = '0;
    end else begin
      case (stateQ)
        RUN: begin
          if (halt) begin
            stateD = DUMP;
            idxD   = '0;
          end
        end
        DUMP: begin
          if (dump.dump_ready) begin
            if (dumpLast) stateD = DONE;
            else          idxD   = dumpIdx + IW'(1);
          end
        end
        DONE:    stateD = DONE;
        default: stateD = RUN;
      endcase
    end
  end

  always_comb begin
    dumpData = '0;
    if (stateQ == DUMP) begin
      for (int i = 0; i < NCNT; i++) begin
        if (dumpIdx == IW'(i)) dumpData = cnt[i];
      end
    end
  end

  assign dump.dump_valid = (stateQ == DUMP);
  assign dump.dump_data  = dumpData;
  assign dump.dump_idx   = dumpIdx;
  assign dump.dump_last  = dumpLast;
  assign ovf             = ovfQ;
  assign state           = stateQ;

endmodule

// File: tb/tb_perf_event_monitor.sv
// tb/tb_perf_event_monitor.sv - randomized and directed bench for perf_event_monitor
// Three instances share stimulus: 32-bit wrap, 4-bit wrap and 4-bit saturate.
module tb_perf_event_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       clear;
  logic       retire;
  logic       halt;
  logic       dumpReady;
  logic [3:0] eventIn;
  logic [5:0] ovf0, ovf1, ovf2;
  logic [1:0] st0, st1, st2;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  perf_event_monitor_if #(.CNT_WIDTH(32), .IW(3)) if0 ();
  perf_event_monitor_if #(.CNT_WIDTH(4),  .IW(3)) if1 ();
  perf_event_monitor_if #(.CNT_WIDTH(4),  .IW(3)) if2 ();

  assign if0.dump_ready = dumpReady;
  assign if1.dump_ready = dumpReady;
  assign if2.dump_ready = dumpReady;

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(32), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .retire(retire),
    .event_in(eventIn), .halt(halt), .dump(if0), .ovf(ovf0), .state(st0));

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(0)) u1 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .retire(retire),
    .event_in(eventIn), .halt(halt), .dump(if1), .ovf(ovf1), .state(st1));

  perf_event_monitor #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(1)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .retire(retire),
    .event_in(eventIn), .halt(halt), .dump(if2), .ovf(ovf2), .state(st2));

  // Reference model: counter values as plain integers, state as 0=RUN 1=DUMP 2=DONE
  longint unsigned mCnt [3][6];
  logic [5:0]      mOvf [3];
  longint unsigned maxv [3] = '{64'hFFFF_FFFF, 64'd15, 64'd15};
  bit              sat  [3] = '{1'b0, 1'b0, 1'b1};
  int              mState;
  int              mIdx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 6; k++) mCnt[d][k] = 0;
      mOvf[d] = '0;
    end
    mState = 0;
    mIdx   = 0;
  endtask

  task automatic modelStep();
    logic [5:0] incs;
    if (!rst || clear) begin
      modelReset();
    end else begin
      incs = {eventIn, retire, 1'b1};
      if (mState == 0 && enable) begin
        for (int d = 0; d < 3; d++) begin
          for (int k = 0; k < 6; k++) begin
            if (incs[k]) begin
              if (mCnt[d][k] == maxv[d]) begin
                mOvf[d][k] = 1'b1;
                if (!sat[d]) mCnt[d][k] = 0;
              end else begin
                mCnt[d][k] = mCnt[d][k] + 1;
              end
            end
          end
        end
      end
      if (mState == 0 && halt) begin
        mState = 1;
        mIdx   = 0;
      end else if (mState == 1 && dumpReady) begin
        if (mIdx == 5) mState = 2;
        else           mIdx   = mIdx + 1;
      end
    end
  endtask

  task automatic checkDut(input int d, input logic [1:0] st, input logic [5:0] ov,
                          input logic v, input logic [2:0] idx, input logic [31:0] data,
                          input logic last);
    check($sformatf("state%0d", d), st, 64'(mState));
    check($sformatf("ovf%0d", d), ov, mOvf[d]);
    check($sformatf("valid%0d", d), v, mState == 1);
    if (mState == 1) begin
      check($sformatf("idx%0d", d), idx, 64'(mIdx));
      check($sformatf("data%0d", d), data, mCnt[d][mIdx]);
      check($sformatf("last%0d", d), last, mIdx == 5);
    end
  endtask

  task automatic checkAll();
    checkDut(0, st0, ovf0, if0.dump_valid, if0.dump_idx, if0.dump_data, if0.dump_last);
    checkDut(1, st1, ovf1, if1.dump_valid, if1.dump_idx, 32'(if1.dump_data), if1.dump_last);
    checkDut(2, st2, ovf2, if2.dump_valid, if2.dump_idx, 32'(if2.dump_data), if2.dump_last);
  endtask

  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; clear = 1'b0; retire = 1'b0;
    halt = 1'b0; eventIn = '0; dumpReady = 1'b0;
    modelReset();
    #1;
    checkAll();
    repeat (2) cycle();
    rst = 1'b1;

    // basic dump with backpressure in the middle
    clear = 1'b1; cycle(); clear = 1'b0;
    enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      retire  = (c < 5);
      eventIn = (c < 3) ? 4'b0001 : 4'b0000;
      halt    = (c == 9);
      cycle();
    end
    retire = 1'b0; eventIn = '0; halt = 1'b0; enable = 1'b0;
    check("basic_state", st0, 2'b01);
    check("basic_w0", if0.dump_data, 10);
    dumpReady = 1'b1; cycle();
    check("basic_w1", if0.dump_data, 5);
    cycle();
    check("basic_w2", if0.dump_data, 3);
    dumpReady = 1'b0;
    repeat (3) begin
      cycle();
      check("bp_idx", if0.dump_idx, 2);
      check("bp_data", if0.dump_data, 3);
      check("bp_valid", if0.dump_valid, 1);
    end
    dumpReady = 1'b1; cycle();
    check("basic_idx3", if0.dump_idx, 3);
    check("basic_w3", if0.dump_data, 0);
    cycle(); cycle();
    check("basic_idx5", if0.dump_idx, 5);
    check("basic_last", if0.dump_last, 1);
    cycle();
    check("basic_done", st0, 2'b10);
    check("done_valid", if0.dump_valid, 0);

    // clear from DONE
    clear = 1'b1; cycle(); clear = 1'b0;
    check("clr_done_state", st0, 2'b00);

    // overflow on 4-bit counters
    enable = 1'b1; eventIn = 4'b0001;
    repeat (17) cycle();
    eventIn = '0; halt = 1'b1; cycle();
    halt = 1'b0; enable = 1'b0; dumpReady = 1'b1;
    cycle(); cycle();
    check("ovf_idx", if1.dump_idx, 2);
    check("ovf_wrap_c2", if1.dump_data, 1);
    check("ovf_sat_c2", if2.dump_data, 15);
    check("ovf_wrap_flag", ovf1[2], 1);
    check("ovf_sat_flag", ovf2[2], 1);

    // clear mid-dump
    clear = 1'b1; cycle(); clear = 1'b0;
    check("clr_dump_state", st1, 2'b00);
    check("clr_dump_ovf", ovf1, 0);

    // clear beats same-cycle event and halt
    enable = 1'b1; eventIn = 4'b0010; halt = 1'b1; clear = 1'b1;
    cycle();
    clear = 1'b0; halt = 1'b0; eventIn = '0; enable = 1'b0;
    check("prio_state", st0, 2'b00);
    check("prio_valid", if0.dump_valid, 0);
    halt = 1'b1; cycle(); halt = 1'b0;
    repeat (3) cycle();
    check("prio_idx", if0.dump_idx, 3);
    check("prio_c3", if0.dump_data, 0);

    // asynchronous reset mid-dump
    dumpReady = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_state", st0, 2'b00);
    check("rst_valid", if0.dump_valid, 0);
    check("rst_data", if0.dump_data, 0);
    check("rst_last", if0.dump_last, 0);
    check("rst_idx", if0.dump_idx, 0);
    modelReset();
    checkAll();
    cycle();
    rst = 1'b1;
    enable = 1'b1; dumpReady = 1'b1;
    repeat (3) cycle();
    halt = 1'b1; cycle(); halt = 1'b0;
    check("post_rst_w0", if0.dump_data, 4);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      enable    = ($urandom % 4) != 0;
      retire    = $urandom % 2;
      eventIn   = 4'($urandom);
      halt      = ($urandom % 16) == 0;
      clear     = ($urandom % 64) == 0;
      dumpReady = ($urandom % 3) != 0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/perf_event_monitor.md
PERF_EVENT_MONITOR -- requirements
Module: perf_event_monitor

Interface
REQ-001 Parameter NUM_EVENTS, default 4, SHALL set the number of generic event inputs (1..16).
REQ-002 Parameter CNT_WIDTH, default 32, SHALL set the width of every counter (4..32).
REQ-003 Parameter SATURATE, default 0, SHALL select overflow mode: 0 = wrap, 1 = saturate.
REQ-004 Localparam NCNT = NUM_EVENTS+2 SHALL be the total counter count; IW = clog2(NCNT).
REQ-005 clk  in  1  sole clock; all state SHALL update on posedge clk.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  counting qualifier.
REQ-008 clear  in  1  synchronous counter/flag clear.
REQ-009 retire  in  1  one instruction retired this cycle.
REQ-010 event_in  in  NUM_EVENTS  per-cycle event strobes (cache req/hit etc.).
REQ-011 halt  in  1  processor halted; triggers freeze and dump.
REQ-012 dump_ready  in  1  consumer accepts dump word.
REQ-013 dump_valid  out  1  dump word valid.
REQ-014 dump_data  out  CNT_WIDTH  counter value being dumped.
REQ-015 dump_idx  out  IW  counter index being dumped.
REQ-016 dump_last  out  1  current word is index NCNT-1.
REQ-017 ovf  out  NCNT  sticky per-counter overflow flags.
REQ-018 state  out  2  RUN=00, DUMP=01, DONE=10.

Function
REQ-019 Counter map SHALL be: idx 0 = cycles, idx 1 = retired instructions, idx 2+i = event_in[i].
REQ-020 In RUN with enable=1, cycle counter SHALL increment every cycle; retire counter when retire=1; counter 2+i when event_in[i]=1.
REQ-021 Outside RUN, or with enable=0, no counter SHALL change except via clear.
REQ-022 In RUN, halt=1 SHALL still count that cycle's events, then state SHALL be DUMP next cycle with dump_idx=0.
REQ-023 In DUMP, dump_valid SHALL be 1, dump_data SHALL equal counter[dump_idx], dump_last SHALL equal (dump_idx==NCNT-1).
REQ-024 A transfer SHALL occur on a cycle with dump_valid=1 and dump_ready=1; dump_idx SHALL then increment by 1.
REQ-025 While dump_ready=0, dump_valid, dump_idx and dump_data SHALL hold stable.
REQ-026 Transfer of the last word SHALL move state to DONE next cycle; dump_valid SHALL be 0 in DONE and RUN.
REQ-027 halt SHALL be ignored in DUMP and DONE.
REQ-028 clear=1 in any state SHALL zero all counters and ovf, reset dump_idx to 0, and enter RUN next cycle; clear SHALL take priority over same-cycle increments and halt.
REQ-029 SATURATE=0: increment at all-ones SHALL wrap to 0 and set ovf[idx].
REQ-030 SATURATE=1: increment at all-ones SHALL hold all-ones and set ovf[idx].
REQ-031 ovf bits SHALL be sticky until clear or reset.
REQ-032 Counter arithmetic SHALL be unsigned, CNT_WIDTH bits, at most +1 per counter per cycle.

Reset
REQ-033 rst=0 SHALL immediately (asynchronously) force state=RUN, all counters 0, ovf=0, dump_idx=0, dump_valid=0, dump_last=0, dump_data=0.
REQ-034 Reset asserted mid-DUMP SHALL abort the dump with no further transfers; the first posedge after release SHALL count normally.

Verification
REQ-035 Reset: assert rst=0 mid-cycle -> all outputs 0, state=00 without waiting for a clock edge.
REQ-036 Basic dump: enable=1 for 10 cycles, retire=1 on 5, event_in[0]=1 on 3, halt on 10th -> words (0,10),(1,5),(2,3),(3,0)...; dump_last on idx NCNT-1; state=10 after.
REQ-037 Backpressure: dump_ready=0 for 3 cycles mid-dump -> dump_idx/dump_data constant, dump_valid=1 throughout, no skipped index.
REQ-038 Overflow: CNT_WIDTH=4, 17 event_in[0] pulses -> SATURATE=0 gives counter 2 = 1, ovf[2]=1; SATURATE=1 gives 15, ovf[2]=1.
REQ-039 Priority: clear and event_in[1] and halt together in RUN -> counter 3 = 0, state stays RUN, no dump.
REQ-040 Clear from DONE and mid-DUMP -> state RUN next cycle, all counters and ovf 0, counting resumes.
